// File: rtl/load_conditioner_pkg.sv
// Shared types and constants for the load-button conditioner.
// The FSM encoding keeps the debounced level in bit 1, so level decodes
// straight from a flop with no combinational glitching.
package load_conditioner_pkg;

  localparam int CNT_W                   = 24;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_CYCLES   = 25_000_000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE         = 2'b00;
  localparam state_t ST_PRESS_WAIT   = 2'b01;
  localparam state_t ST_HELD         = 2'b10;
  localparam state_t ST_RELEASE_WAIT = 2'b11;

  // Debounced level is high in HELD and RELEASE_WAIT only.
  function automatic logic level_of(state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/load_conditioner_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, any bus width.
// Each bit is synchronized independently; the switch bus is only sampled
// once the button has been stable for many cycles, so bit skew is harmless.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/load_conditioner.sv
// Load push-button conditioner: synchronizes the button and switch bus,
// debounces the button and emits a one-cycle load strobe with the captured
// switch word on each accepted press.
// Optional feature: define LOAD_CONDITIONER_AUTOREPEAT_EN to emit further
// strobes every REPEAT_CYCLES cycles while the button stays held.
module load_conditioner
  import load_conditioner_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic             load_conditioner_clk,
  input  logic             load_conditioner_rst,
  input  logic             load_conditioner_btn,
  input  logic [WIDTH-1:0] load_conditioner_sw,
  output logic             load_conditioner_load,
  output logic [WIDTH-1:0] load_conditioner_value,
  output logic             load_conditioner_level
);

  // Count value that completes DEBOUNCE_CYCLES consecutive stable samples
  // (the entry sample into a WAIT state is sample number one, count 0).
  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       btn_sync;
  logic             btn_s;
  logic [WIDTH-1:0] sw_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             load_q, load_d;
  logic [WIDTH-1:0] value_q, value_d;

  sync_2ff #(.WIDTH(1)) u_sync_btn (
    .clk_i  (load_conditioner_clk),
    .rst_ni (load_conditioner_rst),
    .d_i    (load_conditioner_btn),
    .q_o    (btn_sync)
  );

  sync_2ff #(.WIDTH(WIDTH)) u_sync_sw (
    .clk_i  (load_conditioner_clk),
    .rst_ni (load_conditioner_rst),
    .d_i    (load_conditioner_sw),
    .q_o    (sw_s)
  );

  assign btn_s = btn_sync[0];

  // Saturating increment keeps the debounce counter from ever wrapping.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
  localparam int              REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_TERM = REP_W'(REPEAT_CYCLES);

  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc = rep_q + REP_W'(1);
`endif

  // Debounce FSM next-state, strobe and capture decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    value_d = value_q;
`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (btn_s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_TERM) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          load_d  = 1'b1;
          value_d = sw_s;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
        else if (rep_inc >= REP_TERM) begin
          load_d  = 1'b1;
          value_d = sw_s;
          rep_d   = '0;
        end else begin
          rep_d = rep_inc;
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        // A high sample is a release glitch: go back without a new strobe.
        if (btn_s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_TERM) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
    // Every entry into HELD restarts the repeat period.
    if ((state_d == ST_HELD) && (state_q != ST_HELD)) begin
      rep_d = '0;
    end
`endif
  end

  // State, counter and output registers with asynchronous clear.
  always_ff @(posedge load_conditioner_clk or negedge load_conditioner_rst) begin
    if (!load_conditioner_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      value_q <= value_d;
    end
  end

`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
  // Repeat-period counter, only present when auto-repeat is built in.
  always_ff @(posedge load_conditioner_clk or negedge load_conditioner_rst) begin
    if (!load_conditioner_rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign load_conditioner_load  = load_q;
  assign load_conditioner_value = value_q;
  assign load_conditioner_level = level_of(state_q);

endmodule

// File: tb/tb_load_conditioner.sv
// Self-checking bench for load_conditioner: directed scenarios followed by
// random button/switch activity, all compared against a window-based model
// (level flips after DB consecutive synchronized samples of the other value).
`timescale 1ns/1ps
module tb_load_conditioner;

  localparam int W  = 16;
  localparam int DB = 4;
  localparam int RP = 8;
`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
  localparam int EXP_HOLD_STROBES = 4;
`else
  localparam int EXP_HOLD_STROBES = 1;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         btn   = 1'b0;
  logic [W-1:0] sw    = '0;
  logic         load;
  logic [W-1:0] value;
  logic         level;

  load_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .load_conditioner_clk   (clk),
    .load_conditioner_rst   (rst_n),
    .load_conditioner_btn   (btn),
    .load_conditioner_sw    (sw),
    .load_conditioner_load  (load),
    .load_conditioner_value (value),
    .load_conditioner_level (level)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  logic         m_b1, m_b2;
  logic [W-1:0] m_s1, m_s2;
  logic         m_lvl, m_load;
  logic [W-1:0] m_val;
  int           m_run;
`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
  bit           m_held;
  int           m_rep;
`endif

  // Observation bookkeeping from the DUT outputs.
  int cyc              = 0;
  int dut_strobes      = 0;
  int first_strobe_cyc = -1;

  task automatic model_reset();
    m_b1 = 0; m_b2 = 0; m_s1 = '0; m_s2 = '0;
    m_lvl = 0; m_load = 0; m_val = '0; m_run = 0;
`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
    m_held = 0; m_rep = 0;
`endif
  endtask

  task automatic model_edge();
    logic         smp;
    logic [W-1:0] swv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    smp = m_b2; swv = m_s2;
    m_b2 = m_b1; m_s2 = m_s1;
    m_b1 = btn;  m_s1 = sw;
    m_load = 0;
    if (smp != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == DB) begin
      m_lvl = ~m_lvl;
      m_run = 0;
      if (m_lvl) begin
        m_load = 1;
        m_val  = swv;
      end
    end
`ifdef LOAD_CONDITIONER_AUTOREPEAT_EN
    if (m_lvl && smp && m_held) begin
      m_rep++;
      if (m_rep == RP) begin
        m_rep  = 0;
        m_load = 1;
        m_val  = swv;
      end
    end else begin
      m_rep = 0;
    end
    m_held = m_lvl && smp;
`endif
  endtask

  task automatic expect_int(string tag, int got, int exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check(string tag);
    compared++;
    assert (load === m_load) else begin
      mismatched++;
      $error("FAIL %s_load cyc=%0d got=%b exp=%b", tag, cyc, load, m_load);
    end
    compared++;
    assert (level === m_lvl) else begin
      mismatched++;
      $error("FAIL %s_level cyc=%0d got=%b exp=%b", tag, cyc, level, m_lvl);
    end
    compared++;
    assert (value === m_val) else begin
      mismatched++;
      $error("FAIL %s_value cyc=%0d got=%h exp=%h", tag, cyc, value, m_val);
    end
    if (load === 1'b1) begin
      dut_strobes++;
      if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check(tag);
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    expect_int("rst_load", int'(load), 0);
    expect_int("rst_level", int'(level), 0);
    expect_int("rst_value", int'(value), 0);
    repeat (cycles) tick("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    int s0;
    int n;
    model_reset();
    #2;
    do_reset(3);

    // Clean press with sw=A5C3, held 20 cycles, then release.
    sw = 16'hA5C3;
    btn = 0;
    repeat (10) tick("idle");
    first_strobe_cyc = -1;
    s0 = dut_strobes;
    n = 0;
    c0 = cyc;
    btn = 1;
    repeat (20) tick("press");
    expect_int("press_latency", first_strobe_cyc - c0, DB + 2);
    expect_int("press_value", int'(value), 'hA5C3);
    expect_int("press_level", int'(level), 1);
    c0 = cyc;
    btn = 0;
    repeat (5) tick("release");
    expect_int("release_level_hold", int'(level), 1);
    tick("release");
    expect_int("release_level_drop", int'(level), 0);
    repeat (6) tick("idle");

    // Bounce 1,0,1,0 then steady 1: one strobe, 6 cycles after the last rise.
    first_strobe_cyc = -1;
    btn = 1; tick("bounce");
    btn = 0; tick("bounce");
    btn = 1; tick("bounce");
    btn = 0; tick("bounce");
    c0 = cyc;
    btn = 1;
    repeat (7) tick("bounce_hold");
    expect_int("bounce_latency", first_strobe_cyc - c0, DB + 2);

    // Switches change while held: captured value must not follow them.
    sw = 16'h0001;
    repeat (3) tick("sw_change");
    expect_int("hold_value", int'(value), 'hA5C3);
    btn = 0;
    repeat (10) tick("idle");
    first_strobe_cyc = -1;
    btn = 1;
    repeat (8) tick("press2");
    expect_int("press2_value", int'(value), 'h0001);
    btn = 0;
    repeat (10) tick("idle");

    // Reset at PRESS_WAIT count 2 with button held: abort, then re-debounce.
    btn = 1;
    repeat (5) tick("pw");
    first_strobe_cyc = -1;
    do_reset(1);
    c0 = cyc;
    repeat (10) tick("after_rst");
    expect_int("rst_restrobe_latency", first_strobe_cyc - c0, DB + 2);

    // Release glitch of 2 cycles while held: level stays, no new strobe.
    s0 = dut_strobes;
    btn = 0;
    repeat (2) tick("glitch");
    btn = 1;
    repeat (4) tick("glitch_hold");
    expect_int("glitch_strobes", dut_strobes - s0, 0);
    expect_int("glitch_level", int'(level), 1);
    btn = 0;
    repeat (10) tick("idle");

    // Held 30 cycles past the first strobe.
    first_strobe_cyc = -1;
    s0 = dut_strobes;
    c0 = cyc;
    btn = 1;
    repeat (DB + 2 + 30) tick("long_hold");
    expect_int("long_hold_latency", first_strobe_cyc - c0, DB + 2);
    expect_int("long_hold_strobes", dut_strobes - s0, EXP_HOLD_STROBES);
    btn = 0;
    repeat (10) tick("idle");

    // Random runs of button levels, switch words and occasional resets.
    for (int k = 0; k < 200; k++) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) sw = W'($urandom);
      n = $urandom_range(1, 2 * DB + 3);
      if ($urandom_range(0, 40) == 0) do_reset(1);
      else repeat (n) tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
